// File: rtl/serial_sub_ctrl_if.sv
// Requester <-> bit-serial subtract controller handshake and operand/result bus.
// ovf exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtract controller: runs one full-subtractor cell LSB-first over WIDTH cycles.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_sub_ctrl_if.slave sif
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_br;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
    logic             r_ovf;
`endif

    logic [1:0]       w_state_next;
    logic             w_idle_or_done;
    logic             w_last;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;

    // Shared one-bit full-subtractor cell.
    assign w_d        = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_br_next  = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (sif.start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: w_state_next = sif.start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_idle_or_done) begin
                r_done <= 1'b0;
                if (sif.start) begin
                    r_sa    <= sif.a;
                    r_sb    <= sif.b;
                    r_res   <= '0;
                    r_br    <= 1'b0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    r_a_msb <= sif.a[WIDTH-1];
                    r_b_msb <= sif.b[WIDTH-1];
`endif
                end
            end else if (r_state == ST_RUN) begin
                r_sa  <= r_sa >> 1;
                r_sb  <= r_sb >> 1;
                r_res <= w_res_next;
                r_br  <= w_br_next;
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    // Result registers only update here, so they hold steady through RUN.
                    r_diff <= w_res_next;
                    r_bout <= w_br_next;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                    r_ovf  <= (r_a_msb != r_b_msb) && (w_res_next[WIDTH-1] != r_a_msb);
`endif
                end
            end else begin
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end
        end
    end

    assign sif.busy = r_busy;
    assign sif.done = r_done;
    assign sif.diff = r_diff;
    assign sif.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign sif.ovf  = r_ovf;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl (WIDTH=8); ovf checks compile in with SERIAL_SUB_OVF_EN.
module tb_serial_sub_ctrl;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cycles;
    int   pulses;

    serial_sub_ctrl_if #(.WIDTH(8)) bus ();

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .sif (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (observed=hang expected=finish)");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until busy drops (bounded); returns edges taken after the accepting edge.
    task automatic wait_not_busy(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input logic [7:0] a_v, input logic [7:0] b_v, input logic [7:0] exp_d,
                         input logic exp_b, input logic exp_o, input string tag);
        int n;
        bus.a     = a_v;
        bus.b     = b_v;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.a     = ~a_v;
        bus.b     = ~b_v;
        wait_not_busy(n);
        check({tag, " busy cycles"}, n, 8);
        check({tag, " done"}, {31'd0, bus.done}, 1);
        check({tag, " diff"}, {24'd0, bus.diff}, {24'd0, exp_d});
        check({tag, " bout"}, {31'd0, bus.bout}, {31'd0, exp_b});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, exp_o});
`endif
        step();
        check({tag, " done cleared"}, {31'd0, bus.done}, 0);
        check({tag, " diff held"}, {24'd0, bus.diff}, {24'd0, exp_d});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        step();
        step();
        check("reset busy", {31'd0, bus.busy}, 0);
        check("reset done", {31'd0, bus.done}, 0);
        check("reset diff", {24'd0, bus.diff}, 0);
        check("reset bout", {31'd0, bus.bout}, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        step();
        check("idle busy", {31'd0, bus.busy}, 0);

        // Basic vectors, including modular wrap and equal operands.
        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "5-3");
        do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "3-5");
        do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "0-1");
        do_op(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, "A5-A5");
        do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "80-01");
        do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "7F-FF");
        do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "10-01");
        do_op(8'h10, 8'hF0, 8'h20, 1'b1, 1'b0, "10-F0");

        // start re-asserted at E3 with new operands is ignored.
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ign diff held in run", {24'd0, bus.diff}, 8'h20);
        step();
        step();
        bus.a     = 8'h09;
        bus.b     = 8'h04;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("ign still busy", {31'd0, bus.busy}, 1);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        check("ign done at E8", {31'd0, bus.done}, 1);
        check("ign diff", {24'd0, bus.diff}, 8'h02);
        check("ign bout", {31'd0, bus.bout}, 0);
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        check("ign single pulse", pulses, 1);
        check("ign idle after", {31'd0, bus.busy}, 0);

        // Back-to-back with start held high.
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        bus.start = 1'b1;
        step();
        bus.a     = 8'h20;
        bus.b     = 8'h10;
        cycles    = 0;
        while (bus.done !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
        check("b2b first latency", cycles, 8);
        check("b2b first diff", {24'd0, bus.diff}, 8'h02);
        cycles = 0;
        step();
        cycles++;
        check("b2b accepted in done", {31'd0, bus.busy}, 1);
        while (bus.done !== 1'b1 && cycles < 20) begin
            step();
            cycles++;
        end
        check("b2b pulse spacing", cycles, 9);
        check("b2b second diff", {24'd0, bus.diff}, 8'h10);
        check("b2b second bout", {31'd0, bus.bout}, 0);
        bus.start = 1'b0;
        step();
        check("b2b done cleared", {31'd0, bus.done}, 0);
        check("b2b idle", {31'd0, bus.busy}, 0);

        // Reset mid-run after a previous result of 0x02.
        do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "pre-rst 5-3");
        bus.a     = 8'h40;
        bus.b     = 8'h01;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 0);
        check("abort done", {31'd0, bus.done}, 0);
        check("abort diff", {24'd0, bus.diff}, 0);
        check("abort bout", {31'd0, bus.bout}, 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort ovf", {31'd0, bus.ovf}, 0);
`endif
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done === 1'b1) pulses++;
        end
        check("abort no pulse", pulses, 0);
        do_op(8'h0C, 8'h05, 8'h07, 1'b0, 1'b0, "post-rst C-5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
Name: serial_sub_ctrl

Overview:
- Bit-serial subtract controller. It sequences a single full-subtractor cell (difference = a^b^bin; borrow = ~a&b | ~(a^b)&bin) over WIDTH clock cycles to compute diff = a - b.
- It owns the operand shift registers, the borrow flip-flop, the bit counter and the start/done handshake.
- It sits between a requester that issues operands and the shared one-bit subtractor datapath. This trades area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when state is IDLE or DONE
- a  input  WIDTH  minuend; captured on the accepting edge
- b  input  WIDTH  subtrahend; captured on the accepting edge
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; diff/bout valid
- diff  output  WIDTH  registered result a-b mod 2^WIDTH
- bout  output  1  final borrow; 1 iff a < b unsigned
- ovf  output  1  signed overflow (only with SERIAL_SUB_OVF_EN)

Behaviour:
- Reset: synchronous, checked at every rising edge and overriding everything.
  - state=IDLE; busy=0, done=0, diff=0, bout=0 (ovf=0).
  - Shift registers, borrow FF and counter cleared.
  - start is ignored on a reset edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN when start=1. This is edge E0.
    - Load sa=a, sb=b, br=0, cnt=0, busy=1, done=0.
  - IDLE -> IDLE when start=0.
  - DONE -> IDLE when start=0, with done=0.
  - RUN: at each edge Ek (k=1..WIDTH), process bit k-1 LSB-first.
    - d=sa[0]^sb[0]^br.
    - br<=(~sa[0]&sb[0])|(~(sa[0]^sb[0])&br).
    - sa, sb shift right by 1. d shifts into the result shift-register MSB. cnt<=cnt+1.
  - RUN -> DONE at edge EWIDTH, i.e. when cnt==WIDTH-1 before the edge.
    - diff<=final result shift register; bout<=final borrow.
    - busy<=0, done<=1.
- Latency: done is high in the cycle after EWIDTH. That is WIDTH edges after the accepting edge.
- Throughput: start held high in DONE gives back-to-back operations, one result per WIDTH+1 cycles.
- diff/bout hold their last value until the next DONE entry. They do not change during RUN.
- start while busy=1 is ignored, with no queuing. Operand changes during RUN have no effect.
- Reset mid-RUN aborts the operation. There is no done pulse and the previous diff is cleared to 0.
- Arithmetic: unsigned, modulo 2^WIDTH. bout is the borrow out of the MSB.
  - Example: a==b gives diff=0, bout=0.

Optional Feature:
- Macro SERIAL_SUB_OVF_EN.
- When defined:
  - Port ovf exists, registered at EWIDTH alongside diff.
  - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using captured operand sign bits stored at E0.
  - ovf is reset to 0 and holds with diff.
- When undefined:
  - Port ovf and the sign-capture flops are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse at E0.
  - busy=1 for 8 cycles.
  - done=1 in the cycle after E8, with diff=0x02, bout=0.
- a=0x03, b=0x05 -> diff=0xFE, bout=1. a=0x00, b=0x01 -> diff=0xFF, bout=1. a=b=0xA5 -> diff=0x00, bout=0.
- With SERIAL_SUB_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
  - a=0x10, b=0x01 -> ovf=0.
- start re-asserted with new operands (0x09, 0x04) at E3 of a 0x05-0x03 run.
  - The second request is ignored. The result is 0x02 at the expected cycle, with a single done pulse.
- start held high continuously, using 0x05-0x03 then 0x20-0x10.
  - The second request is accepted in the DONE cycle.
  - done pulses are 9 cycles apart, giving diff=0x02 then 0x10.
- rst asserted at E4 of a run after a previous result of 0x02.
  - Next cycle: busy=0, done=0, diff=0, bout=0.
  - No done pulse follows. A new start then completes normally.
